// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the readback FSM state encoding.
package cpu_pkg;

    localparam int WIDTH      = 32;
    localparam int ADDR_STEP  = 4;
    localparam int CNT_W      = 8;

    // Read data appears this many cycles after the read strobe. The
    // readback FSM's single WAIT state assumes a value of 1, so the CPU
    // memory must keep this value.
    localparam int MEM_RD_LAT = 1;

    typedef enum logic [2:0] {
        RB_IDLE    = 3'd0,
        RB_ISSUE   = 3'd1,
        RB_WAIT    = 3'd2,
        RB_PRESENT = 3'd3,
        RB_FINISH  = 3'd4
    } rb_state_t;

endpackage

// File: rtl/mem_readback_if.sv
// Control, memory read port and output stream of the readback block.
// master: the readback engine. slave: controller / memory / consumer side.
interface mem_readback_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) ();
    import cpu_pkg::*;

    logic             start;
    logic [WIDTH-1:0] base_addr;
    logic [CNT_W-1:0] word_count;

    logic [WIDTH-1:0] mem_addr;
    logic             mem_rd;
    logic [WIDTH-1:0] mem_data;

    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_addr;
    logic             out_valid;
    logic             out_ready;

    logic             busy;
    logic             done;

    modport master (
        input  start, base_addr, word_count, mem_data, out_ready,
        output mem_addr, mem_rd, out_data, out_addr, out_valid, busy, done
    );

    modport slave (
        output start, base_addr, word_count, mem_data, out_ready,
        input  mem_addr, mem_rd, out_data, out_addr, out_valid, busy, done
    );

endinterface

// File: rtl/mem_readback.sv
// Sequential memory reader: reads word_count words from base_addr at a
// fixed byte stride and presents each word with its address on a
// valid/ready stream. At most one read is outstanding.
module mem_readback #(
    parameter int WIDTH     = 32,
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    mem_readback_if.master  bus
);
    import cpu_pkg::*;

    rb_state_t        state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;          // address of the current word
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;  // held between reads
    logic [CNT_W-1:0] rem_q, rem_d;            // words not yet read
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] out_addr_q, out_addr_d;

    logic [WIDTH-1:0] addr_next;

    // Stride arithmetic wraps modulo 2^WIDTH.
    assign addr_next = addr_q + WIDTH'(ADDR_STEP);

    // Next-state and datapath updates; everything holds by default.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        rem_d      = rem_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;

        case (state_q)
            RB_IDLE: begin
                if (bus.start) begin
                    addr_d = bus.base_addr;
                    rem_d  = bus.word_count;
                    if (bus.word_count != '0) begin
                        mem_addr_d = bus.base_addr;
                        state_d    = RB_ISSUE;
                    end else begin
                        state_d    = RB_FINISH;
                    end
                end
            end
            RB_ISSUE: begin
                state_d = RB_WAIT;
            end
            RB_WAIT: begin
                // Memory answers one cycle after the strobe.
                out_data_d = bus.mem_data;
                out_addr_d = addr_q;
                if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
                state_d    = RB_PRESENT;
            end
            RB_PRESENT: begin
                if (bus.out_ready) begin
                    addr_d = addr_next;
                    if (rem_q == '0) begin
                        state_d = RB_FINISH;
                    end else begin
                        // Preload the read address so it is valid during ISSUE.
                        mem_addr_d = addr_next;
                        state_d    = RB_ISSUE;
                    end
                end
            end
            RB_FINISH: begin
                state_d = RB_IDLE;
            end
            default: begin
                state_d = RB_IDLE;
            end
        endcase
    end

    // State and datapath registers; low reset aborts any readback.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RB_IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            rem_q      <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            rem_q      <= rem_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = (state_q == RB_ISSUE);
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_valid = (state_q == RB_PRESENT);
    assign bus.busy      = (state_q != RB_IDLE);
    assign bus.done      = (state_q == RB_FINISH);

endmodule

// File: tb/tb_mem_readback.sv
// Directed bench for mem_readback with a 1-cycle-latency memory model
// that is loaded through an addrIn/dataTemp/wrIn write port.
module tb_mem_readback;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_readback_if #(.WIDTH(32), .CNT_W(8)) bus ();

    mem_readback #(.WIDTH(32), .ADDR_STEP(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: 64 words indexed by addr[7:2].
    logic [31:0] addrIn, dataTemp;
    logic        wrIn;
    logic [31:0] mem [64];

    always @(posedge clk) begin
        if (wrIn) mem[addrIn[7:2]] <= dataTemp;
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr[7:2]];
        else            bus.mem_data <= 32'hDEAD_BEEF;
    end

    int checks = 0;
    int errors = 0;

    // Observations collected by run_block.
    logic [31:0] rd_q[$];
    logic [31:0] dq[$];
    logic [31:0] aq[$];
    int done_cyc, first_rd, first_valid, valid_cnt, overlap, hold_bad;

    logic [31:0] exp_data [4] = '{32'h8062_0800, 32'h6080_0000, 32'h6400_0000, 32'h74E3_FFFC};
    logic [31:0] exp_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        addrIn = a; dataTemp = d; wrIn = 1'b1;
        step();
        wrIn = 1'b0;
    endtask

    // Starts a block and records strobes, handshakes and the done cycle.
    // Cycle 1 is the cycle after the edge that accepts start.
    task automatic run_block(input logic [31:0] base, input logic [7:0] cnt,
                             input int stall_idx, input int stall_len, input int restart_cyc);
        int idx, stalled;
        logic [31:0] held;
        rd_q.delete(); dq.delete(); aq.delete();
        done_cyc = -1; first_rd = -1; first_valid = -1;
        valid_cnt = 0; overlap = 0; hold_bad = 0;
        idx = 0; stalled = 0; held = '0;
        bus.base_addr = base; bus.word_count = cnt; bus.out_ready = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.base_addr = 32'h5555_5550; bus.word_count = 8'd9;
        for (int c = 1; c <= 80; c++) begin
            if (bus.mem_rd) begin
                rd_q.push_back(bus.mem_addr);
                if (first_rd < 0) first_rd = c;
            end
            if (bus.out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = c;
                if (bus.mem_rd) overlap++;
                if (idx == stall_idx && stalled < stall_len) begin
                    if (stalled == 0) held = bus.out_data;
                    else if (bus.out_data !== held) hold_bad++;
                    stalled++;
                    bus.out_ready = 1'b0;
                end else begin
                    bus.out_ready = 1'b1;
                    dq.push_back(bus.out_data);
                    aq.push_back(bus.out_addr);
                    idx++;
                end
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            if (c == restart_cyc) begin
                bus.start = 1'b1; bus.base_addr = 32'h0000_0040; bus.word_count = 8'd1;
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        checks++; if (bus.mem_addr  !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_rd    !== 1'b0)  begin errors++; $display("FAIL reset_mem_rd got %b want 0", bus.mem_rd); end
        checks++; if (bus.out_data  !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
        checks++; if (bus.out_addr  !== 32'h0) begin errors++; $display("FAIL reset_out_addr got %h want 0", bus.out_addr); end
        checks++; if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.busy      !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done      !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        run_block(32'h0, 8'd4, -1, 0, -1);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL basic_done_cycle got %0d want 13", done_cyc); end
        checks++; if (first_rd !== 1) begin errors++; $display("FAIL basic_first_rd got %0d want 1", first_rd); end
        checks++; if (first_valid !== 3) begin errors++; $display("FAIL basic_first_valid got %0d want 3", first_valid); end
        checks++; if (dq.size() !== 4 || rd_q.size() !== 4) begin errors++; $display("FAIL basic_count got %0d words %0d reads want 4", dq.size(), rd_q.size()); end
        for (int i = 0; i < 4 && i < dq.size() && i < rd_q.size(); i++) begin
            checks++; if (dq[i] !== exp_data[i]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, dq[i], exp_data[i]); end
            checks++; if (aq[i] !== exp_addr[i]) begin errors++; $display("FAIL basic_addr[%0d] got %h want %h", i, aq[i], exp_addr[i]); end
            checks++; if (rd_q[i] !== exp_addr[i]) begin errors++; $display("FAIL basic_mem_addr[%0d] got %h want %h", i, rd_q[i], exp_addr[i]); end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_backpressure();
        run_block(32'h0, 8'd4, 1, 5, -1);
        checks++; if (done_cyc !== 18) begin errors++; $display("FAIL bp_done_cycle got %0d want 18", done_cyc); end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold got %0d changes want 0", hold_bad); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL bp_rd_while_valid got %0d want 0", overlap); end
        checks++; if (rd_q.size() !== 4 || dq.size() !== 4) begin errors++; $display("FAIL bp_count got %0d reads %0d words want 4", rd_q.size(), dq.size()); end
        for (int i = 0; i < 4 && i < dq.size(); i++) begin
            checks++; if (dq[i] !== exp_data[i] || aq[i] !== exp_addr[i]) begin
                errors++; $display("FAIL bp_word[%0d] got %h@%h want %h@%h", i, dq[i], aq[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_zero();
        run_block(32'h8, 8'd0, -1, 0, -1);
        checks++; if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", done_cyc); end
        checks++; if (rd_q.size() !== 0) begin errors++; $display("FAIL zero_reads got %0d want 0", rd_q.size()); end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL zero_valid got %0d want 0", valid_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_wrap();
        run_block(32'hFFFF_FFFC, 8'd2, -1, 0, -1);
        checks++; if (done_cyc !== 7) begin errors++; $display("FAIL wrap_done_cycle got %0d want 7", done_cyc); end
        checks++; if (rd_q.size() !== 2 || dq.size() !== 2) begin
            errors++; $display("FAIL wrap_count got %0d reads %0d words want 2", rd_q.size(), dq.size());
        end else begin
            checks++; if (rd_q[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_mem_addr0 got %h want fffffffc", rd_q[0]); end
            checks++; if (rd_q[1] !== 32'h0) begin errors++; $display("FAIL wrap_mem_addr1 got %h want 0", rd_q[1]); end
            checks++; if (aq[1] !== 32'h0 || aq[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_out_addr got %h,%h want fffffffc,0", aq[0], aq[1]); end
            checks++; if (dq[0] !== 32'hA5A5_0001 || dq[1] !== 32'h8062_0800) begin errors++; $display("FAIL wrap_data got %h,%h want a5a50001,80620800", dq[0], dq[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        bus.base_addr = 32'h0; bus.word_count = 8'd4; bus.out_ready = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 6; c++) step();
        // cycle 6: word 2 in PRESENT
        checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 32'h4 || bus.out_data !== 32'h6080_0000) begin
            errors++; $display("FAIL mid_present got v=%b %h@%h want 1 60800000@4", bus.out_valid, bus.out_data, bus.out_addr);
        end
        bus.out_ready = 1'b0;
        reset = 1'b0; bus.start = 1'b1;   // reset must win over start
        step();
        reset = 1'b1; bus.start = 1'b0; bus.out_ready = 1'b1;
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_rd !== 1'b0 || bus.out_data !== 32'h0 || bus.out_addr !== 32'h0) begin
            errors++; $display("FAIL mid_reset_data got ma=%h rd=%b od=%h oa=%h want all 0", bus.mem_addr, bus.mem_rd, bus.out_data, bus.out_addr);
        end
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ctrl got v=%b busy=%b done=%b want 0", bus.out_valid, bus.busy, bus.done);
        end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done || bus.busy) dones++;
            step();
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL mid_no_done got %0d active cycles want 0", dones); end
        run_block(32'h0, 8'd4, -1, 0, -1);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL mid_rerun_done got %0d want 13", done_cyc); end
        checks++; if (dq.size() !== 4) begin
            errors++; $display("FAIL mid_rerun_count got %0d want 4", dq.size());
        end else if (dq[0] !== exp_data[0] || dq[3] !== exp_data[3] || aq[3] !== 32'hC) begin
            errors++; $display("FAIL mid_rerun_data got %h,%h@%h want 80620800,74e3fffc@c", dq[0], dq[3], aq[3]);
        end
    endtask

    task automatic test_start_busy();
        int extra;
        run_block(32'h0, 8'd4, -1, 0, 2);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL busy_done_cycle got %0d want 13", done_cyc); end
        checks++; if (rd_q.size() !== 4 || dq.size() !== 4) begin
            errors++; $display("FAIL busy_count got %0d reads %0d words want 4", rd_q.size(), dq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (rd_q[i] !== exp_addr[i] || dq[i] !== exp_data[i]) begin
                    errors++; $display("FAIL busy_word[%0d] got %h@%h want %h@%h", i, dq[i], rd_q[i], exp_data[i], exp_addr[i]);
                end
            end
        end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.busy || bus.mem_rd || bus.done) extra++;
            step();
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_after got %0d active cycles want 0", extra); end
    endtask

    initial begin
        wrIn = 1'b0; addrIn = '0; dataTemp = '0;
        bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0; bus.out_ready = 1'b0;
        test_reset();
        write_word(32'h0, 32'h8062_0800);
        write_word(32'h4, 32'h6080_0000);
        write_word(32'h8, 32'h6400_0000);
        write_word(32'hC, 32'h74E3_FFFC);
        write_word(32'hFFFF_FFFC, 32'hA5A5_0001);
        step();
        test_basic();
        test_backpressure();
        test_zero();
        test_wrap();
        test_reset_mid();
        test_start_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
